// File: rtl/multi_channel_clock_divider_if.sv
// Configuration port of the multi-channel divider: one retune request per handshake,
// with a one-cycle error strobe for out-of-range channel numbers.
interface multi_channel_clock_divider_if #(
    parameter int WIDTH = 32,
    parameter int CHW   = 2
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CHW-1:0]   cfg_channel;
    logic [WIDTH-1:0] cfg_increment;
    logic             cfg_sync;
    logic             cfg_error;

    modport master (
        output cfg_valid, cfg_channel, cfg_increment, cfg_sync,
        input  cfg_ready, cfg_error
    );

    modport slave (
        input  cfg_valid, cfg_channel, cfg_increment, cfg_sync,
        output cfg_ready, cfg_error
    );
endinterface

// File: rtl/multi_channel_clock_divider.sv
// Multi-channel phase-accumulator divider: per-channel MSB slow clock and wrap tick,
// with run-time increment retune applied at the target's next wrap or immediately with phase sync.
module multi_channel_clock_divider_lane #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] DEFAULT_INC = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic             sync_clr,
    input  logic [WIDTH-1:0] inc_new,
    output logic             slow_clk,
    output logic             tick,
    output logic             wrap,
    output logic             inc_zero
);
    logic [WIDTH-1:0] acc_q, acc_d, inc_q, inc_d;
    logic             tick_q, tick_d;
    logic [WIDTH:0]   sum;

    always_comb begin
        sum    = {1'b0, acc_q} + {1'b0, inc_q};
        acc_d  = en ? sum[WIDTH-1:0] : '0;
        tick_d = en & sum[WIDTH];
        inc_d  = inc_q;
        if (load) begin
            inc_d = inc_new;
            // A synced retune restarts the phase and swallows this edge's tick.
            if (sync_clr) begin
                acc_d  = '0;
                tick_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q  <= '0;
            inc_q  <= DEFAULT_INC;
            tick_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            inc_q  <= inc_d;
            tick_q <= tick_d;
        end
    end

    assign slow_clk = acc_q[WIDTH-1];
    assign tick     = tick_q;
    assign wrap     = en & sum[WIDTH];
    assign inc_zero = (inc_q == '0);
endmodule

module multi_channel_clock_divider #(
    parameter int          WIDTH        = 32,
    parameter int          CHANNELS     = 4,
    parameter int          FREQUENCY_IN = 50000000,
    parameter int          DEFAULT_FREQ = 1,
    parameter logic [63:0] DEFAULT_INC  =
        (((64'd1 << WIDTH) * 64'(DEFAULT_FREQ)) - 64'd1) / 64'(FREQUENCY_IN) + 64'd1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [CHANNELS-1:0]          enable,
    multi_channel_clock_divider_if.slave cfg,
    output logic [CHANNELS-1:0]          slowClk,
    output logic [CHANNELS-1:0]          tick
);
    localparam int               CHW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [WIDTH-1:0] DEF_W = DEFAULT_INC[WIDTH-1:0];

    typedef enum logic {IDLE, PENDING} state_e;

    state_e           state_q, state_d;
    logic [CHW-1:0]   ch_q, ch_d;
    logic [WIDTH-1:0] new_inc_q, new_inc_d;
    logic             sync_q, sync_d;
    logic             ready_q, ready_d;
    logic             error_q, error_d;
    logic             bad_ch;

    logic [CHANNELS-1:0] wrap, inc_zero, apply;

    // Only a non-power-of-two channel count leaves unused channel codes.
    if ((1 << CHW) > CHANNELS) begin : g_chk
        localparam logic [CHW-1:0] LAST = CHW'(CHANNELS - 1);
        assign bad_ch = (cfg.cfg_channel > LAST);
    end else begin : g_nochk
        assign bad_ch = 1'b0;
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        assign apply[i] = (state_q == PENDING) && (ch_q == CHW'(i)) &&
                          (sync_q || !enable[i] || inc_zero[i] || wrap[i]);

        multi_channel_clock_divider_lane #(
            .WIDTH       (WIDTH),
            .DEFAULT_INC (DEF_W)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .en       (enable[i]),
            .load     (apply[i]),
            .sync_clr (sync_q),
            .inc_new  (new_inc_q),
            .slow_clk (slowClk[i]),
            .tick     (tick[i]),
            .wrap     (wrap[i]),
            .inc_zero (inc_zero[i])
        );
    end

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        new_inc_d = new_inc_q;
        sync_d    = sync_q;
        ready_d   = ready_q;
        error_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg.cfg_valid) begin
                    if (bad_ch) begin
                        error_d = 1'b1;
                    end else begin
                        state_d   = PENDING;
                        ch_d      = cfg.cfg_channel;
                        new_inc_d = cfg.cfg_increment;
                        sync_d    = cfg.cfg_sync;
                        ready_d   = 1'b0;
                    end
                end
            end
            PENDING: begin
                if (|apply) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            ch_q      <= '0;
            new_inc_q <= '0;
            sync_q    <= 1'b0;
            ready_q   <= 1'b1;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            new_inc_q <= new_inc_d;
            sync_q    <= sync_d;
            ready_q   <= ready_d;
            error_q   <= error_d;
        end
    end

    assign cfg.cfg_ready = ready_q;
    assign cfg.cfg_error = error_q;
endmodule
